boron_key_sched_param: RTL

Parametrised, handshaked BORON round-key generator supporting both RECTANGLE-style key sizes (80 and 128 bit). It owns the round counter internally and streams 64-bit round keys K0..K_ROUNDS to the datapath under valid/ready flow control. Optionally, it stores the whole schedule so the keys can be replayed in reverse order for decryption. It sits between the key input register and the BORON round datapath.

---
 rtl/boron_key_sched_param.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/boron_key_sched_param.sv
// -----------------------------------------------------------------------------
// boron_key_sched_param
//
// Handshaked BORON round-key generator for 80- and 128-bit keys. Owns the
// round counter and streams the 64-bit round keys K0..K_ROUNDS to the round
// datapath under valid/ready flow control.
//
// Optional feature macro: BORON_KEY_RK_STORE_EN
//   Defined   : adds a (ROUNDS+1)x64 round-key store plus FILL/REPLAY states,
//               so rev_i=1 replays the schedule in reverse order (decryption).
//   Undefined : forward order only; a start with rev_i=1 is rejected with err_o.
//
// Parameters
//   KEY_W   : key size, 80 or 128
//   ROUNDS  : number of key updates, 1..31 (ROUNDS+1 round keys)
//
// Ports
//   clk_i       : clock, all state changes on the rising edge
//   rst_i       : synchronous active-high reset
//   key_in_i    : master key, sampled when start_i is accepted
//   start_i     : request a schedule (accepted only in IDLE)
//   rev_i       : sampled with start_i, 0 = forward, 1 = reverse
//   rk_ready_i  : consumer takes rk_o this cycle
//   rk_valid_o  : rk_o / rk_idx_o valid
//   rk_o        : 64-bit round key
//   rk_idx_o    : index of the key on rk_o
//   busy_o      : high in every state except IDLE
//   done_o      : one-cycle pulse when a schedule completes
//   err_o       : one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module boron_key_sched_param #(
  parameter int KEY_W  = 128,
  parameter int ROUNDS = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [KEY_W-1:0] key_in_i,
  input  logic             start_i,
  input  logic             rev_i,
  input  logic             rk_ready_i,
  output logic             rk_valid_o,
  output logic [63:0]      rk_o,
  output logic [4:0]       rk_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  // Row geometry: 128-bit keys are four 32-bit rows, 80-bit keys five 16-bit
  // rows. The S-box layer covers the low quarter of each row's columns.
  localparam int RW   = (KEY_W == 80) ? 16 : 32;
  localparam int NR   = (KEY_W == 80) ? 5 : 4;
  localparam int NCOL = RW / 4;
  localparam logic [4:0] LAST = 5'(ROUNDS);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("boron_key_sched_param: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("boron_key_sched_param: ROUNDS must be in 1..31");
  end

`ifdef BORON_KEY_RK_STORE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_FILL, ST_REPLAY} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FWD} state_t;
`endif

  state_t             state_q;
  logic [KEY_W-1:0]   key_q;
  logic [4:0]         cnt_q;
  logic [63:0]        rk_q;
  logic               valid_q;
  logic               done_q;
  logic               err_q;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  // Round key = low 16 bits of rows 0..3, row0 in the MSBs.
  function automatic logic [63:0] extract(input logic [KEY_W-1:0] k);
    return {k[KEY_W-RW+15 -: 16], k[KEY_W-2*RW+15 -: 16],
            k[KEY_W-3*RW+15 -: 16], k[KEY_W-4*RW+15 -: 16]};
  endfunction

  // ---------------------------------------------------------------------------
  // One key update applied to key_q, with round constant cnt_q+1.
  // ---------------------------------------------------------------------------
  logic [RW-1:0]    row     [NR];
  logic [RW-1:0]    sb      [NR];
  logic [RW-1:0]    nx      [NR];
  logic [3:0]       col_out [NCOL];
  logic [KEY_W-1:0] key_upd;
  logic [4:0]       rc;

  assign rc = cnt_q + 5'd1;

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      row[r] = key_q[KEY_W-1-r*RW -: RW];
    end
  end

  // Column j is the nibble {row3[j], row2[j], row1[j], row0[j]}, row0 = LSB.
  for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
    assign col_out[gi] = sbox({row[3][gi], row[2][gi], row[1][gi], row[0][gi]});
  end

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      sb[r] = row[r];
    end
    for (int j = 0; j < NCOL; j++) begin
      for (int r = 0; r < 4; r++) begin
        sb[r][j] = col_out[j][r];
      end
    end
  end

  if (NR == 4) begin : g_mix128
    always_comb begin
      nx[0] = {sb[0][23:0], sb[0][31:24]} ^ sb[1] ^ {27'd0, rc};
      nx[1] = sb[2];
      nx[2] = {sb[2][15:0], sb[2][31:16]} ^ sb[3];
      nx[3] = sb[0];
    end
  end else begin : g_mix80
    always_comb begin
      nx[0] = {sb[0][7:0], sb[0][15:8]} ^ sb[1] ^ {11'd0, rc};
      nx[1] = sb[2];
      nx[2] = sb[3];
      nx[3] = {sb[3][3:0], sb[3][15:4]} ^ sb[4];
      nx[4] = sb[0];
    end
  end

  always_comb begin
    key_upd = '0;
    for (int r = 0; r < NR; r++) begin
      key_upd[KEY_W-1-r*RW -: RW] = nx[r];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      rk_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (!rev_i) begin
              state_q <= ST_FWD;
              key_q   <= key_in_i;
              cnt_q   <= '0;
              rk_q    <= extract(key_in_i);
              valid_q <= 1'b1;
            end else begin
`ifdef BORON_KEY_RK_STORE_EN
              state_q <= ST_FILL;
              key_q   <= key_in_i;
              cnt_q   <= '0;
`else
              err_q   <= 1'b1;
`endif
            end
          end
        end
        ST_FWD: begin
          if (rk_ready_i) begin
            if (cnt_q == LAST) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              key_q <= key_upd;
              rk_q  <= extract(key_upd);
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
`ifdef BORON_KEY_RK_STORE_EN
        // One store write per cycle; counter stays at LAST for the replay.
        ST_FILL: begin
          if (cnt_q == LAST) begin
            state_q <= ST_REPLAY;
          end else begin
            key_q <= key_upd;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        // First REPLAY cycle (valid_q low) primes the registered store read.
        ST_REPLAY: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (rk_ready_i) begin
            if (cnt_q == 5'd0) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BORON_KEY_RK_STORE_EN
  // ---------------------------------------------------------------------------
  // Round-key store, registered read. The read address runs one step ahead
  // on a handshake so the next key is on rk_o in the following cycle.
  // ---------------------------------------------------------------------------
  logic [63:0] store [ROUNDS+1];
  logic [63:0] rd_q;
  logic [4:0]  raddr;

  always_comb begin
    raddr = cnt_q;
    if (state_q == ST_REPLAY && valid_q && rk_ready_i && cnt_q != 5'd0) begin
      raddr = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == ST_FILL) begin
      store[cnt_q] <= extract(key_q);
    end
    rd_q <= store[raddr];
  end

  assign rk_o = (state_q == ST_REPLAY) ? rd_q : rk_q;
`else
  assign rk_o = rk_q;
`endif

  assign rk_valid_o = valid_q;
  assign rk_idx_o   = cnt_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
